// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the controller state encoding and the default operand width.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Used as the building block of the ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// Purely combinational WIDTH-bit adder built as a chain of full_adder cells.
// The carry-in is tied low and the carry-out is exposed.
module ripple_carry_adder #(
  parameter int WIDTH = shift_add_multiplier_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per cycle.
// Takes WIDTH CALC cycles per product, then pulses done for one cycle.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               last;

  assign addend = mplier[0] ? mcand : '0;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // The carry re-enters at the top as the accumulator shifts right, so it is never dropped.
  assign acc_nxt = {carry, sum, acc[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mcand  <= multiplicand;
        mplier <= multiplier;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= acc_nxt;
        mplier <= mplier >> 1;
        if (last) begin
          product <= acc_nxt;
          cnt     <= CNT_W'(WIDTH);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
